// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction
// fetch and execute-stage loads/stores. Holds one pending EX request, aligns
// byte lanes, and sign/zero-extends load data back to writeback.
module mem_port_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] EX_MEMaddr,
    input  logic [3:0]  EX_MEMrden,
    input  logic        EX_MEMrden_SEXT,
    input  logic [3:0]  EX_MEMwren,
    input  logic [31:0] EX_MEMwrdata,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvld,
    output logic [31:0] if_rdata,
    output logic        MEM_x_rd_vld,
    output logic [31:0] MEM_x_rd,
    output logic        ex_stall,
    output logic        ex_ovf,
    output logic        ex_misalign,
    output logic [31:0] ram_addr,
    output logic        ram_rden,
    output logic [3:0]  ram_wren,
    output logic [31:0] ram_wrdata,
    input  logic [31:0] ram_rdata
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_WAIT = 1'b1;

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [1:0]      CNT_LAST   = 2'(RD_LAT);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    // Read-in-flight tracking
    logic [0:0]      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            rd_is_ex_q, rd_is_ex_d;
    logic [1:0]      rd_lo_q, rd_lo_d;
    logic [3:0]      rd_mask_q, rd_mask_d;
    logic            rd_sext_q, rd_sext_d;

    // One-entry EX request buffer
    logic            buf_vld_q, buf_vld_d;
    logic [31:0]     buf_addr_q, buf_addr_d;
    logic [3:0]      buf_rden_q, buf_rden_d;
    logic [3:0]      buf_wren_q, buf_wren_d;
    logic            buf_sext_q, buf_sext_d;
    logic [31:0]     buf_wrdata_q, buf_wrdata_d;

    logic [SC_W-1:0] starve_q, starve_d;

    // Registered read results
    logic            if_rvld_q, if_rvld_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic            mem_vld_q, mem_vld_d;
    logic [31:0]     mem_rd_q, mem_rd_d;

    // Issue decision
    logic            new_ex, free, starve_hit, capture;
    logic            issue_if, issue_buf, issue_new, issue_ex;
    logic [31:0]     sel_addr, sel_wrdata;
    logic [3:0]      sel_rden, sel_wren;
    logic            sel_sext, sel_ld;
    logic [7:0]      lanes;

    // Fetch addresses are word aligned; the low bits carry no information.
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^if_addr[1:0];

    // Shift a lane mask to its byte offset; bits [7:4] are lanes past the word.
    function automatic logic [7:0] lane_shift(input logic [3:0] mask, input logic [1:0] lo);
        return {4'b0000, mask} << lo;
    endfunction

    // Right-align the addressed lanes, then extend from the top lane of the access.
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [3:0] mask, input logic sext);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        if (mask[3])      return sh;
        else if (mask[2]) return {{8{sext & sh[23]}}, sh[23:0]};
        else if (mask[1]) return {{16{sext & sh[15]}}, sh[15:0]};
        else              return {{24{sext & sh[7]}}, sh[7:0]};
    endfunction

    assign if_rvld      = if_rvld_q;
    assign if_rdata     = if_rdata_q;
    assign MEM_x_rd_vld = mem_vld_q;
    assign MEM_x_rd     = mem_rd_q;
    assign ex_stall     = buf_vld_q;

    // Arbitrate the port, drive the RAM, update buffer/FSM/starvation next-state.
    always_comb begin
        new_ex     = |(EX_MEMrden | EX_MEMwren);
        free       = (state_q == S_IDLE) || (cnt_q == CNT_LAST);
        capture    = (state_q == S_RD_WAIT) && (cnt_q == CNT_LAST);
        starve_hit = if_req && (starve_q == STARVE_LIM);

        // Nothing issues while reset is asserted, so the RAM strobes stay quiet.
        issue_if  = 1'b0;
        issue_buf = 1'b0;
        issue_new = 1'b0;
        if (rst_n && free) begin
            if (starve_hit)     issue_if  = 1'b1;
            else if (buf_vld_q) issue_buf = 1'b1;
            else if (new_ex)    issue_new = 1'b1;
            else if (if_req)    issue_if  = 1'b1;
        end
        issue_ex = issue_buf | issue_new;

        sel_addr   = issue_buf ? buf_addr_q   : EX_MEMaddr;
        sel_rden   = issue_buf ? buf_rden_q   : EX_MEMrden;
        sel_wren   = issue_buf ? buf_wren_q   : EX_MEMwren;
        sel_sext   = issue_buf ? buf_sext_q   : EX_MEMrden_SEXT;
        sel_wrdata = issue_buf ? buf_wrdata_q : EX_MEMwrdata;
        sel_ld     = |sel_rden;
        lanes      = lane_shift(sel_ld ? sel_rden : sel_wren, sel_addr[1:0]);

        if_gnt      = issue_if;
        ram_addr    = 32'h0;
        ram_rden    = 1'b0;
        ram_wren    = 4'h0;
        ram_wrdata  = 32'h0;
        ex_misalign = 1'b0;
        if (issue_if) begin
            ram_addr = {if_addr[31:2], 2'b00};
            ram_rden = 1'b1;
        end else if (issue_ex) begin
            ram_addr    = {sel_addr[31:2], 2'b00};
            ex_misalign = |lanes[7:4];
            if (sel_ld) begin
                ram_rden = 1'b1;
            end else begin
                ram_wren   = lanes[3:0];
                ram_wrdata = sel_wrdata << {sel_addr[1:0], 3'b000};
            end
        end

        // A slot drained this cycle can take the incoming request straight away.
        buf_vld_d    = buf_vld_q & ~issue_buf;
        buf_addr_d   = buf_addr_q;
        buf_rden_d   = buf_rden_q;
        buf_wren_d   = buf_wren_q;
        buf_sext_d   = buf_sext_q;
        buf_wrdata_d = buf_wrdata_q;
        ex_ovf       = 1'b0;
        if (rst_n && new_ex && !issue_new) begin
            if (!buf_vld_d) begin
                buf_vld_d    = 1'b1;
                buf_addr_d   = EX_MEMaddr;
                buf_rden_d   = EX_MEMrden;
                buf_wren_d   = EX_MEMwren;
                buf_sext_d   = EX_MEMrden_SEXT;
                buf_wrdata_d = EX_MEMwrdata;
            end else begin
                ex_ovf = 1'b1;
            end
        end

        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_is_ex_d = rd_is_ex_q;
        rd_lo_d    = rd_lo_q;
        rd_mask_d  = rd_mask_q;
        rd_sext_d  = rd_sext_q;
        if (state_q == S_RD_WAIT) begin
            if (capture) state_d = S_IDLE;
            else         cnt_d   = 2'(cnt_q + 2'd1);
        end
        if (issue_if || (issue_ex && sel_ld)) begin
            state_d    = S_RD_WAIT;
            cnt_d      = 2'd1;
            rd_is_ex_d = issue_ex;
            rd_lo_d    = sel_addr[1:0];
            rd_mask_d  = sel_rden;
            rd_sext_d  = sel_sext;
        end

        if_rvld_d  = capture & ~rd_is_ex_q;
        mem_vld_d  = capture & rd_is_ex_q;
        if_rdata_d = if_rvld_d ? ram_rdata : if_rdata_q;
        mem_rd_d   = mem_vld_d ? extend_load(ram_rdata, rd_lo_q, rd_mask_q, rd_sext_q) : mem_rd_q;

        starve_d = starve_q;
        if (issue_if)                              starve_d = '0;
        else if (if_req && (starve_q < STARVE_LIM)) starve_d = SC_W'(starve_q + SC_W'(1));
    end

    // State, buffer and result registers; async reset abandons any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            rd_is_ex_q   <= 1'b0;
            rd_lo_q      <= 2'd0;
            rd_mask_q    <= 4'h0;
            rd_sext_q    <= 1'b0;
            buf_vld_q    <= 1'b0;
            buf_addr_q   <= 32'h0;
            buf_rden_q   <= 4'h0;
            buf_wren_q   <= 4'h0;
            buf_sext_q   <= 1'b0;
            buf_wrdata_q <= 32'h0;
            starve_q     <= '0;
            if_rvld_q    <= 1'b0;
            if_rdata_q   <= 32'h0;
            mem_vld_q    <= 1'b0;
            mem_rd_q     <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_is_ex_q   <= rd_is_ex_d;
            rd_lo_q      <= rd_lo_d;
            rd_mask_q    <= rd_mask_d;
            rd_sext_q    <= rd_sext_d;
            buf_vld_q    <= buf_vld_d;
            buf_addr_q   <= buf_addr_d;
            buf_rden_q   <= buf_rden_d;
            buf_wren_q   <= buf_wren_d;
            buf_sext_q   <= buf_sext_d;
            buf_wrdata_q <= buf_wrdata_d;
            starve_q     <= starve_d;
            if_rvld_q    <= if_rvld_d;
            if_rdata_q   <= if_rdata_d;
            mem_vld_q    <= mem_vld_d;
            mem_rd_q     <= mem_rd_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A uses RD_LAT=1, instance B RD_LAT=3.
module tb_mem_port_arbiter;

    logic clk, rst_n;
    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:63];

    logic [31:0] a_addr, a_wrdata, a_if_addr, a_if_rdata, a_rd, a_ram_addr, a_ram_wrdata, a_ram_rdata;
    logic [3:0]  a_rden, a_wren, a_ram_wren;
    logic        a_sext, a_if_req, a_if_gnt, a_if_rvld, a_rd_vld, a_stall, a_ovf, a_mis, a_ram_rden;

    logic [31:0] b_addr, b_wrdata, b_if_addr, b_if_rdata, b_rd, b_ram_addr, b_ram_wrdata, b_ram_rdata;
    logic [3:0]  b_rden, b_wren, b_ram_wren;
    logic        b_sext, b_if_req, b_if_gnt, b_if_rvld, b_rd_vld, b_stall, b_ovf, b_mis, b_ram_rden;

    mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .EX_MEMaddr(a_addr), .EX_MEMrden(a_rden), .EX_MEMrden_SEXT(a_sext),
        .EX_MEMwren(a_wren), .EX_MEMwrdata(a_wrdata),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
        .if_rvld(a_if_rvld), .if_rdata(a_if_rdata),
        .MEM_x_rd_vld(a_rd_vld), .MEM_x_rd(a_rd),
        .ex_stall(a_stall), .ex_ovf(a_ovf), .ex_misalign(a_mis),
        .ram_addr(a_ram_addr), .ram_rden(a_ram_rden), .ram_wren(a_ram_wren),
        .ram_wrdata(a_ram_wrdata), .ram_rdata(a_ram_rdata)
    );

    mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .EX_MEMaddr(b_addr), .EX_MEMrden(b_rden), .EX_MEMrden_SEXT(b_sext),
        .EX_MEMwren(b_wren), .EX_MEMwrdata(b_wrdata),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvld(b_if_rvld), .if_rdata(b_if_rdata),
        .MEM_x_rd_vld(b_rd_vld), .MEM_x_rd(b_rd),
        .ex_stall(b_stall), .ex_ovf(b_ovf), .ex_misalign(b_mis),
        .ram_addr(b_ram_addr), .ram_rden(b_ram_rden), .ram_wren(b_ram_wren),
        .ram_wrdata(b_ram_wrdata), .ram_rdata(b_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: registered read, extra pipeline stages for B
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [0:2];
    always @(posedge clk) begin
        a_pipe    <= a_ram_rden ? mem[a_ram_addr[7:2]] : 32'h0;
        b_pipe[0] <= b_ram_rden ? mem[b_ram_addr[7:2]] : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_ram_rdata = a_pipe;
    assign b_ram_rdata = b_pipe[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_addr = 32'h0; a_rden = 4'h0; a_sext = 1'b0; a_wren = 4'h0; a_wrdata = 32'h0;
        a_if_req = 1'b0; a_if_addr = 32'h0;
    endtask

    task automatic b_idle();
        b_addr = 32'h0; b_rden = 4'h0; b_sext = 1'b0; b_wren = 4'h0; b_wrdata = 32'h0;
        b_if_req = 1'b0; b_if_addr = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_idle();
        b_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (a_ram_rden !== 1'b0) begin errors++; $display("FAIL rst_ram_rden: got %b want 0", a_ram_rden); end
        checks++; if (a_ram_addr !== 32'h0) begin errors++; $display("FAIL rst_ram_addr: got %h want 0", a_ram_addr); end
        checks++; if ({a_if_gnt, a_if_rvld, a_rd_vld, a_stall, a_ovf, a_mis} !== 6'b0) begin
            errors++; $display("FAIL rst_flags: got %b want 000000", {a_if_gnt, a_if_rvld, a_rd_vld, a_stall, a_ovf, a_mis}); end
        checks++; if (a_rd !== 32'h0 || a_if_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_data: got %h/%h want 0/0", a_rd, a_if_rdata); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Issue one load on A from idle; result expected two cycles later (RD_LAT+1).
    task automatic test_load(input string name, input logic [31:0] addr, input logic [3:0] rden,
                             input logic sext, input logic [31:0] exp);
        a_addr = addr; a_rden = rden; a_sext = sext;
        @(negedge clk);
        checks++; if (a_ram_rden !== 1'b1) begin errors++; $display("FAIL %s_rden: got %b want 1", name, a_ram_rden); end
        checks++; if (a_ram_addr !== {addr[31:2], 2'b00}) begin
            errors++; $display("FAIL %s_addr: got %h want %h", name, a_ram_addr, {addr[31:2], 2'b00}); end
        step();
        a_idle();
        @(negedge clk);
        checks++; if (a_rd_vld !== 1'b0) begin errors++; $display("FAIL %s_early_vld: got %b want 0", name, a_rd_vld); end
        step();
        @(negedge clk);
        checks++; if (a_rd_vld !== 1'b1) begin errors++; $display("FAIL %s_vld: got %b want 1", name, a_rd_vld); end
        checks++; if (a_rd !== exp) begin errors++; $display("FAIL %s_data: got %h want %h", name, a_rd, exp); end
        step();
        @(negedge clk);
        checks++; if (a_rd_vld !== 1'b0) begin errors++; $display("FAIL %s_vld_pulse: got %b want 0", name, a_rd_vld); end
        step();
    endtask

    task automatic test_store();
        logic [31:0] t_addr [0:2];
        logic [3:0]  t_mask [0:2];
        logic [31:0] t_data [0:2];
        logic [3:0]  t_wren [0:2];
        logic [31:0] t_wdat [0:2];
        logic        t_mis  [0:2];
        t_addr[0] = 32'h06; t_mask[0] = 4'b0011; t_data[0] = 32'h0000ABCD; t_wren[0] = 4'b1100; t_wdat[0] = 32'hABCD0000; t_mis[0] = 1'b0;
        t_addr[1] = 32'h07; t_mask[1] = 4'b0011; t_data[1] = 32'h0000ABCD; t_wren[1] = 4'b1000; t_wdat[1] = 32'hCD000000; t_mis[1] = 1'b1;
        t_addr[2] = 32'h0D; t_mask[2] = 4'b0001; t_data[2] = 32'h0000005A; t_wren[2] = 4'b0010; t_wdat[2] = 32'h00005A00; t_mis[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_addr = t_addr[i]; a_wren = t_mask[i]; a_wrdata = t_data[i];
            @(negedge clk);
            checks++; if (a_ram_wren !== t_wren[i]) begin errors++; $display("FAIL st%0d_wren: got %b want %b", i, a_ram_wren, t_wren[i]); end
            checks++; if (a_ram_wrdata !== t_wdat[i]) begin errors++; $display("FAIL st%0d_wrdata: got %h want %h", i, a_ram_wrdata, t_wdat[i]); end
            checks++; if (a_ram_addr !== {t_addr[i][31:2], 2'b00}) begin
                errors++; $display("FAIL st%0d_addr: got %h want %h", i, a_ram_addr, {t_addr[i][31:2], 2'b00}); end
            checks++; if (a_mis !== t_mis[i] || a_ram_rden !== 1'b0) begin
                errors++; $display("FAIL st%0d_mis_rden: got %b%b want %b0", i, a_mis, a_ram_rden, t_mis[i]); end
            step();
        end
        a_idle();
        @(negedge clk);
        checks++; if (a_ram_wren !== 4'h0 || a_mis !== 1'b0 || a_stall !== 1'b0) begin
            errors++; $display("FAIL st_after: got wren %b mis %b stall %b want 0000 0 0", a_ram_wren, a_mis, a_stall); end
        step();
        // Both masks nonzero: behaves as a load, no write strobes
        a_addr = 32'h10; a_rden = 4'hF; a_wren = 4'hF; a_wrdata = 32'h11111111;
        @(negedge clk);
        checks++; if (a_ram_rden !== 1'b1 || a_ram_wren !== 4'h0) begin
            errors++; $display("FAIL ldst_both: got rden %b wren %b want 1 0000", a_ram_rden, a_ram_wren); end
        step();
        a_idle();
        repeat (3) step();
    endtask

    task automatic test_starve();
        for (int c = 0; c < 5; c++) begin
            a_if_req = 1'b1; a_if_addr = 32'h22; a_addr = 32'h10; a_rden = 4'hF;
            @(negedge clk);
            checks++; if (a_if_gnt !== (c == 4)) begin errors++; $display("FAIL starve_gnt%0d: got %b want %b", c, a_if_gnt, (c == 4)); end
            checks++; if (a_ram_addr !== ((c == 4) ? 32'h20 : 32'h10) || a_ram_rden !== 1'b1) begin
                errors++; $display("FAIL starve_addr%0d: got %h/%b want %h/1", c, a_ram_addr, a_ram_rden, (c == 4) ? 32'h20 : 32'h10); end
            step();
        end
        a_idle();
        @(negedge clk);
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b want 1", a_stall); end
        checks++; if (a_ram_rden !== 1'b1 || a_ram_addr !== 32'h10 || a_if_gnt !== 1'b0) begin
            errors++; $display("FAIL starve_buf_issue: got %b/%h/%b want 1/00000010/0", a_ram_rden, a_ram_addr, a_if_gnt); end
        step();
        @(negedge clk);
        checks++; if (a_if_rvld !== 1'b1 || a_if_rdata !== 32'h13572468) begin
            errors++; $display("FAIL starve_if_rdata: got %b/%h want 1/13572468", a_if_rvld, a_if_rdata); end
        checks++; if (a_stall !== 1'b0 || a_rd_vld !== 1'b0) begin
            errors++; $display("FAIL starve_stall_clr: got stall %b vld %b want 0 0", a_stall, a_rd_vld); end
        step();
        @(negedge clk);
        checks++; if (a_rd_vld !== 1'b1 || a_rd !== 32'h80011234) begin
            errors++; $display("FAIL starve_buf_result: got %b/%h want 1/80011234", a_rd_vld, a_rd); end
        step();
        repeat (2) step();
    endtask

    task automatic test_overflow();
        b_if_req = 1'b1; b_if_addr = 32'h20;
        @(negedge clk);
        checks++; if (b_if_gnt !== 1'b1 || b_ram_rden !== 1'b1) begin
            errors++; $display("FAIL ovf_if_gnt: got %b/%b want 1/1", b_if_gnt, b_ram_rden); end
        step();
        b_if_req = 1'b0; b_addr = 32'h10; b_rden = 4'hF;
        @(negedge clk);
        checks++; if (b_ram_rden !== 1'b0 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_a_buffered: got rden %b ovf %b want 0 0", b_ram_rden, b_ovf); end
        step();
        b_addr = 32'h14; b_rden = 4'hF;
        @(negedge clk);
        checks++; if (b_ovf !== 1'b1 || b_stall !== 1'b1 || b_ram_rden !== 1'b0) begin
            errors++; $display("FAIL ovf_b_drop: got ovf %b stall %b rden %b want 1 1 0", b_ovf, b_stall, b_ram_rden); end
        step();
        b_idle();
        @(negedge clk);
        checks++; if (b_ram_rden !== 1'b1 || b_ram_addr !== 32'h10 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_a_issue: got %b/%h/%b want 1/00000010/0", b_ram_rden, b_ram_addr, b_ovf); end
        step();
        @(negedge clk);
        checks++; if (b_if_rvld !== 1'b1 || b_if_rdata !== 32'h13572468 || b_stall !== 1'b0) begin
            errors++; $display("FAIL ovf_if_rvld: got %b/%h stall %b want 1/13572468 0", b_if_rvld, b_if_rdata, b_stall); end
        step();
        for (int c = 5; c <= 7; c++) begin
            @(negedge clk);
            checks++; if (b_rd_vld !== (c == 7)) begin errors++; $display("FAIL ovf_vld_c%0d: got %b want %b", c, b_rd_vld, (c == 7)); end
            step();
        end
        checks++; if (b_rd !== 32'h80011234) begin errors++; $display("FAIL ovf_a_data: got %h want 80011234", b_rd); end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_read();
        b_if_req = 1'b1; b_if_addr = 32'h20;
        @(negedge clk);
        checks++; if (b_if_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt: got %b want 1", b_if_gnt); end
        step();
        b_if_req = 1'b0; b_addr = 32'h10; b_rden = 4'hF;
        step();
        b_idle();
        b_if_req = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if ({b_ram_rden, b_if_gnt, b_stall, b_if_rvld, b_rd_vld, b_ovf} !== 6'b0 || b_ram_addr !== 32'h0) begin
            errors++; $display("FAIL rmr_outputs: got %b addr %h want 000000 addr 0",
                {b_ram_rden, b_if_gnt, b_stall, b_if_rvld, b_rd_vld, b_ovf}, b_ram_addr); end
        step();
        b_if_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (b_if_rvld !== 1'b0 || b_rd_vld !== 1'b0 || b_ram_rden !== 1'b0 || b_stall !== 1'b0) begin
                errors++; $display("FAIL rmr_stale%0d: got rvld %b vld %b rden %b stall %b want 0 0 0 0",
                    c, b_if_rvld, b_rd_vld, b_ram_rden, b_stall); end
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h13572468;
        test_reset();
        test_load("lw", 32'h10, 4'hF, 1'b0, 32'hDEADBEEF);
        mem[4] = 32'h80011234;
        test_load("lh_sext", 32'h12, 4'b0011, 1'b1, 32'hFFFF8001);
        test_load("lh_zext", 32'h12, 4'b0011, 1'b0, 32'h00008001);
        test_load("lh_lo_sext", 32'h10, 4'b0011, 1'b1, 32'h00001234);
        test_load("lb_sext", 32'h13, 4'b0001, 1'b1, 32'hFFFFFF80);
        test_load("lb_zext", 32'h13, 4'b0001, 1'b0, 32'h00000080);
        test_load("lb_b1", 32'h11, 4'b0001, 1'b1, 32'h00000012);
        test_store();
        test_starve();
        test_overflow();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
